// File: rtl/btn_event_gen.sv
// btn_event_gen: multi-channel push-button front end.
// Each channel independently synchronises, debounces and tracks its button,
// producing a one-cycle press pulse (plus optional hold-to-repeat pulses),
// a one-cycle release pulse and a clean debounced level. All outputs are
// registered; channels share no state.

module btn_event_gen #(
    parameter int NUM_BTN      = 2,      // independent channels (>=1)
    parameter int NUM_SYNC     = 2,      // synchronizer depth (>=2)
    parameter int BTN_ACTIVE   = 1,      // 1 = active-high pins, 0 = active-low
    parameter int DEBOUNCE     = 1000,   // extra stable cycles to accept a change (>=1)
    parameter int REPEAT_EN    = 1,      // 1 = hold-to-repeat enabled
    parameter int REPEAT_DELAY = 50000,  // press pulse to first repeat (>=1)
    parameter int REPEAT_RATE  = 10000   // spacing of later repeats (>=1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] press_o,
    output logic [NUM_BTN-1:0] release_o,
    output logic [NUM_BTN-1:0] state_o
);

    // Counter widths sized so the terminal values are representable.
    localparam int DBNC_W  = $clog2(DEBOUNCE + 1);
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    // Terminal counts. The repeat counter uses a phase flag: phase 0 times the
    // initial delay from the press pulse, phase 1 times every later repeat.
    localparam logic [DBNC_W-1:0] DBNC_MAX  = DBNC_W'(DEBOUNCE);
    localparam logic [RPT_W-1:0]  RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0]  RPT_NEXT  = RPT_W'(REPEAT_RATE - 1);

    // Per-channel FSM states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch

        // Polarity-normalised raw pin: 1 always means "pressed".
        logic                a;
        // Synchronizer chain; bit NUM_SYNC-1 is the last flop.
        logic [NUM_SYNC-1:0] sync_d, sync_q;
        logic                s;
        // Control state.
        logic [0:0]          st_d, st_q;
        logic [DBNC_W-1:0]   dbnc_d, dbnc_q;
        logic [RPT_W-1:0]    rpt_d, rpt_q;
        logic                phase_d, phase_q;
        logic [RPT_W-1:0]    rpt_tgt;
        // Registered outputs.
        logic                press_d, press_q;
        logic                rel_d, rel_q;
        logic                state_d, state_q;

        assign a       = (BTN_ACTIVE != 0) ? btn_i[i] : ~btn_i[i];
        assign s       = sync_q[NUM_SYNC-1];
        assign rpt_tgt = phase_q ? RPT_NEXT : RPT_FIRST;

        // Shift the normalised pin into the synchronizer chain.
        always_comb begin
            sync_d = {sync_q[NUM_SYNC-2:0], a};
        end

        // Debounce / hold FSM: decides the next state, counters and pulses.
        always_comb begin
            // NOTE: every signal assigned here gets a default first, so no
            // path can leave one unassigned and infer a latch.
            st_d    = st_q;
            dbnc_d  = dbnc_q;
            rpt_d   = rpt_q;
            phase_d = phase_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            state_d = state_q;

            case (st_q)
                ST_IDLE: begin
                    if (!s) begin
                        // Any inactive sample restarts the press qualification.
                        dbnc_d = '0;
                    end else if (dbnc_q != DBNC_MAX) begin
                        dbnc_d = dbnc_q + 1'b1;
                    end else begin
                        st_d    = ST_HELD;
                        press_d = 1'b1;
                        state_d = 1'b1;
                        dbnc_d  = '0;
                        rpt_d   = '0;
                        phase_d = 1'b0;
                    end
                end

                ST_HELD: begin
                    if (s) begin
                        // An active sample aborts any release in progress.
                        dbnc_d = '0;
                        if (REPEAT_EN != 0) begin
                            if (rpt_q == rpt_tgt) begin
                                press_d = 1'b1;
                                rpt_d   = '0;
                                phase_d = 1'b1;
                            end else begin
                                rpt_d = rpt_q + 1'b1;
                            end
                        end
                    end else if (dbnc_q != DBNC_MAX) begin
                        // Release qualification; repeat timing is frozen, so
                        // each aborted-release cycle delays later repeats.
                        dbnc_d = dbnc_q + 1'b1;
                    end else begin
                        st_d    = ST_IDLE;
                        rel_d   = 1'b1;
                        state_d = 1'b0;
                        dbnc_d  = '0;
                        rpt_d   = '0;
                        phase_d = 1'b0;
                    end
                end

                default: begin
                    st_d = ST_IDLE;
                end
            endcase
        end

        // Channel registers with synchronous reset; reset also clears the
        // synchronizer so a still-held button is re-qualified from scratch.
        always_ff @(posedge clk_i) begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            if (rst_i) begin
                sync_q  <= '0;
                st_q    <= ST_IDLE;
                dbnc_q  <= '0;
                rpt_q   <= '0;
                phase_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
                state_q <= 1'b0;
            end else begin
                sync_q  <= sync_d;
                st_q    <= st_d;
                dbnc_q  <= dbnc_d;
                rpt_q   <= rpt_d;
                phase_q <= phase_d;
                press_q <= press_d;
                rel_q   <= rel_d;
                state_q <= state_d;
            end
        end

        assign press_o[i]   = press_q;
        assign release_o[i] = rel_q;
        assign state_o[i]   = state_q;

    end : g_ch

endmodule : btn_event_gen

// File: tb/tb_btn_event_gen.sv
// Directed testbench for btn_event_gen.
// Three instances share clock and reset: u_rep (active-high, auto-repeat),
// u_norep (active-high, no repeat) and u_low (active-low, no repeat).
// A negedge monitor logs every output pulse as edge*1000+inst*100+kind*10+ch
// (kind 0 = press, 1 = release); each test lists the pulses it expects and
// compares the log against them, alongside direct level checks.

module tb_btn_event_gen;

    localparam int NB = 2;

    logic          clk;
    logic          rst;
    logic [NB-1:0] btn_a, btn_b, btn_c;
    logic [NB-1:0] pa, ra, sa;
    logic [NB-1:0] pb, rb, sb;
    logic [NB-1:0] pc, rc, sc;

    int n_total = 0;
    int n_bad   = 0;
    int edge_n  = 0;
    int log_q[$];
    int exp_q[$];

    btn_event_gen #(
        .NUM_BTN(NB), .NUM_SYNC(2), .BTN_ACTIVE(1), .DEBOUNCE(4),
        .REPEAT_EN(1), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) u_rep (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_a),
        .press_o(pa), .release_o(ra), .state_o(sa)
    );

    btn_event_gen #(
        .NUM_BTN(NB), .NUM_SYNC(2), .BTN_ACTIVE(1), .DEBOUNCE(4),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) u_norep (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_b),
        .press_o(pb), .release_o(rb), .state_o(sb)
    );

    btn_event_gen #(
        .NUM_BTN(NB), .NUM_SYNC(2), .BTN_ACTIVE(0), .DEBOUNCE(4),
        .REPEAT_EN(0), .REPEAT_DELAY(10), .REPEAT_RATE(3)
    ) u_low (
        .clk_i(clk), .rst_i(rst), .btn_i(btn_c),
        .press_o(pc), .release_o(rc), .state_o(sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter: after an edge it holds that edge's index.
    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic int enc(input int e, input int inst, input int kind, input int ch);
        return e * 1000 + inst * 100 + kind * 10 + ch;
    endfunction

    // Pulse monitor, fixed order: inst, then press/release, then channel.
    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) if (pa[c] === 1'b1) log_q.push_back(enc(edge_n, 0, 0, c));
        for (int c = 0; c < NB; c++) if (ra[c] === 1'b1) log_q.push_back(enc(edge_n, 0, 1, c));
        for (int c = 0; c < NB; c++) if (pb[c] === 1'b1) log_q.push_back(enc(edge_n, 1, 0, c));
        for (int c = 0; c < NB; c++) if (rb[c] === 1'b1) log_q.push_back(enc(edge_n, 1, 1, c));
        for (int c = 0; c < NB; c++) if (pc[c] === 1'b1) log_q.push_back(enc(edge_n, 2, 0, c));
        for (int c = 0; c < NB; c++) if (rc[c] === 1'b1) log_q.push_back(enc(edge_n, 2, 1, c));
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic ev(input int e, input int inst, input int kind, input int ch);
        exp_q.push_back(enc(e, inst, kind, ch));
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check(tag, (i < log_q.size()) ? log_q[i] : -1, exp_q[i]);
        log_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, p, k2;

        // 1. Reset with buttons held; fresh press with full latency afterwards.
        rst   = 1'b1;
        btn_a = 2'b11;
        btn_b = 2'b00;
        btn_c = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_reset_outputs", {pa, ra, sa, pb, rb, sb, pc, rc, sc}, 18'd0);
        end
        rst = 1'b0;
        k = edge_n + 1;
        ev(k + 6, 0, 0, 0);
        ev(k + 6, 0, 0, 1);
        tick_n(6);
        check("t1_press_early", pa, 2'b00);
        tick();
        check("t1_press", pa, 2'b11);
        check("t1_state", sa, 2'b11);
        tick();
        check("t1_press_width", pa, 2'b00);
        btn_a = 2'b00;
        m = edge_n + 1;
        ev(m + 6, 0, 1, 0);
        ev(m + 6, 0, 1, 1);
        tick_n(7);
        check("t1_release", ra, 2'b11);
        check("t1_state_low", sa, 2'b00);
        tick();
        check_log("t1_log");

        // 2. Clean press/release on channel 0, repeat disabled.
        btn_b = 2'b01;
        k = edge_n + 1;
        ev(k + 6, 1, 0, 0);
        tick_n(7);
        check("t2_press", pb, 2'b01);
        check("t2_state", sb, 2'b01);
        tick();
        btn_b = 2'b00;
        m = edge_n + 1;
        ev(m + 6, 1, 1, 0);
        tick_n(6);
        check("t2_state_hold", sb, 2'b01);
        check("t2_release_early", rb, 2'b00);
        tick();
        check("t2_release", rb, 2'b01);
        check("t2_state_low", sb, 2'b00);
        tick();
        check_log("t2_log");

        // 3. Bounce rejection on channel 1, active-high and active-low together.
        begin
            logic [9:0] pat;
            pat = 10'b1111011110;  // MSB first: 4 high, 1 low, 4 high, 1 low
            for (int i = 9; i >= 0; i--) begin
                btn_b[1] = pat[i];
                btn_c[1] = ~pat[i];
                tick();
            end
        end
        check("t3_no_state_b", sb, 2'b00);
        check("t3_no_state_c", sc, 2'b00);
        btn_b[1] = 1'b1;
        btn_c[1] = 1'b0;
        k = edge_n + 1;
        ev(k + 6, 1, 0, 1);
        ev(k + 6, 2, 0, 1);
        tick_n(7);
        check("t3_press_b", pb, 2'b10);
        check("t3_press_c", pc, 2'b10);
        tick_n(10);
        btn_b[1] = 1'b0;
        btn_c[1] = 1'b1;
        m = edge_n + 1;
        ev(m + 6, 1, 1, 1);
        ev(m + 6, 2, 1, 1);
        tick_n(7);
        check("t3_release_c", rc, 2'b10);
        check("t3_state_c", sc, 2'b00);
        tick();
        check_log("t3_log");

        // 4. Auto-repeat on channel 1, then a 2-cycle glitch mid-hold.
        btn_a = 2'b10;
        k = edge_n + 1;
        p = k + 6;
        ev(p, 0, 0, 1);
        for (int t = p + 10; t <= p + 31; t += 3) ev(t, 0, 0, 1);
        ev(p + 36, 0, 0, 1);
        ev(p + 39, 0, 0, 1);
        ev(p + 42, 0, 0, 1);
        ev(p + 47, 0, 1, 1);
        tick_n(7);
        check("t4_press", pa, 2'b10);
        tick_n(10);
        check("t4_first_repeat", pa, 2'b10);
        tick_n(19);             // now just after edge p+29
        btn_a = 2'b00;
        tick_n(2);              // edges p+30, p+31 sample low
        btn_a = 2'b10;
        tick_n(3);              // after p+34
        check("t4_glitch_no_release", sa, 2'b10);
        tick_n(6);              // after p+40
        btn_a = 2'b00;          // first low sample at p+41
        tick_n(7);
        check("t4_release", ra, 2'b10);
        check("t4_state_low", sa, 2'b00);
        tick();
        check_log("t4_log");

        // 5. Independent channels: staggered presses, simultaneous release.
        btn_a = 2'b01;
        k = edge_n + 1;
        ev(k + 6, 0, 0, 0);
        ev(k + 8, 0, 0, 1);
        ev(k + 15, 0, 1, 0);
        ev(k + 15, 0, 1, 1);
        tick_n(2);
        btn_a = 2'b11;
        tick_n(5);
        check("t5_press_ch0", pa, 2'b01);
        tick_n(2);
        check("t5_press_ch1", pa, 2'b10);
        btn_a = 2'b00;
        tick_n(7);
        check("t5_release_both", ra, 2'b11);
        check("t5_state_low", sa, 2'b00);
        tick();
        check_log("t5_log");

        // 6. Reset mid-hold: no release, then a full-latency fresh press.
        btn_a = 2'b01;
        k = edge_n + 1;
        ev(k + 6, 0, 0, 0);
        tick_n(7);
        check("t6_state_pre", sa, 2'b01);
        tick_n(2);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t6_reset_outputs", {pa, ra, sa}, 6'd0);
        end
        rst = 1'b0;
        k2 = edge_n + 1;
        ev(k2 + 6, 0, 0, 0);
        tick_n(6);
        check("t6_press_early", pa, 2'b00);
        tick();
        check("t6_press", pa, 2'b01);
        check("t6_state", sa, 2'b01);
        btn_a = 2'b00;
        m = edge_n + 1;
        ev(m + 6, 0, 1, 0);
        tick_n(7);
        check("t6_release", ra, 2'b01);
        tick();
        check_log("t6_log");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_btn_event_gen
